mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port synchronous program/data memory between two requesters: port 0 = core
//  (fetch/LD path), port 1 = external loader/debug.
//  Round-robin arbitration with a request/ack handshake; one memory access in flight at a time.
//  Sits between the core's memory interface, the loader, and the memory macro.
// PARAMETERS
//  ADDR_W      8  memory address width (bits)
//  DATA_W      8  memory data width (bits)
//  FIXED_PRIO  0  0 = round-robin; 1 = port 0 always wins a contested IDLE cycle
// PORTS
//  CLK          in   1       clock; all state changes on posedge
//  CLB          in   1       reset, synchronous, active-high
//  req0/req1    in   1       access request, held until the matching ack
//  we0/we1      in   1       1 = write, 0 = read; valid while reqN
//  addr0/addr1  in   ADDR_W  access address; valid while reqN
//  wdata0/1     in   DATA_W  write data; valid while reqN && weN
//  ack0/ack1    out  1       one-cycle completion pulse
//  rdata0/1     out  DATA_W  read data, valid in the ack cycle, held until the next ack
//  mem_en       out  1       memory enable
//  mem_we       out  1       memory write enable
//  mem_addr     out  ADDR_W  memory address
//  mem_wdata    out  DATA_W  memory write data
//  mem_rdata    in   DATA_W  memory read data, 1-cycle latency after mem_en
//  gnt_id       out  1       port owning the current access
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  - States: IDLE -> ACCESS -> RESP -> IDLE. All outputs are registered.
//  - IDLE: if any reqN is sampled high, pick the winner, latch its we/addr/wdata, set gnt_id,
//    go to ACCESS. If no request, stay in IDLE.
//  - ACCESS: mem_en=1, mem_we=latched we, and mem_addr/mem_wdata driven for exactly one cycle.
//    Next state is RESP.
//  - RESP: capture mem_rdata into rdata[gnt_id] (read only; writes leave rdata unchanged).
//    Pulse ack[gnt_id]=1 for one cycle, then go to IDLE.
//  - Latency: req sampled at edge t -> mem_en high t..t+1 -> ack high t+2..t+3.
//    Peak throughput is 1 access per 3 cycles.
//  - A requester must drop reqN in the cycle after ackN. If reqN is still high in IDLE, it is
//    treated as a new request.
//  - Round-robin: pointer rr_last holds the last granted port. On a contested IDLE, the other
//    port wins. An uncontested request always wins. rr_last updates on every grant.
//  - FIXED_PRIO=1: port 0 wins every contest, and rr_last is ignored.
//  - Requests arriving while busy wait (no queue beyond the held req). Address/data changes
//    during an access are ignored because they are latched in IDLE.
//  - Reset values (CLB=1 at an edge, from any state): state=IDLE, rr_last=1 (port 0 favoured
//    first), ack0/1=0, rdata0/1=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, gnt_id=0,
//    busy=0, lock cleared.
//  - Reset mid-operation: the access is abandoned and no ack is issued. If reset coincides with
//    the edge closing ACCESS, the memory write on that edge completes.
//  - Address wrap: none inside the block; addr is passed through unmodified.
// CONFIGURATION
//  ARB_LOCK_EN defined:
//  - Adds inputs lock0/lock1 (1 bit), sampled with reqN in IDLE.
//  - When the granted port's lock is high, ownership persists. The next IDLE considers only
//    that port until it issues a request with lockN=0; that unlocked access completes, then
//    ownership is released.
//  - The other port waits throughout (atomic read-modify-write).
//  - The lock is cleared by reset.
//  ARB_LOCK_EN undefined:
//  - lock0/lock1 ports do not exist. Pure arbitration as above.
// STRUCTURE
//  - Shared package cpu_pkg:
//    - state encodings ARB_IDLE=2'd0, ARB_ACCESS=2'd1, ARB_RESP=2'd2
//    - port IDs PORT_CORE=1'b0, PORT_LDR=1'b1
//    - ADDR_W/DATA_W defaults shared with the core
//  - Sub-module rr_pick2: combinational 2-way picker (req0, req1, last, fixed) -> (valid, id).
//  - FSM, latches and output registers live in mem_port_arbiter.
// TESTING
//  1. Reset: hold CLB=1 for 2 cycles with req0=1. Expect all outputs 0, busy=0, no mem_en.
//  2. Single read: memory[0x10]=0xA5, req0=1, we0=0, addr0=0x10.
//     Expect mem_en pulse with addr 0x10, then ack0 two cycles later with rdata0=0xA5.
//  3. Contention: req0 and req1 both held high for 4 accesses.
//     Expect grant order 0,1,0,1. With FIXED_PRIO=1, expect 0,0,0,0 while req0 stays high.
//  4. Write then read: port1 writes 0x3C to 0x7F, then port0 reads 0x7F.
//     Expect rdata0=0x3C, and rdata1 unchanged by the write.
//  5. Reset mid-access: assert CLB during RESP of a port0 read.
//     Expect no ack0, state IDLE, and a following request serviced normally.
//  6. ARB_LOCK_EN: port1 issues lock1=1 read, then lock1=0 write, with req0 high throughout.
//     Expect both port1 accesses to complete before port0's ack.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the core and its memory port arbiter: default widths,
// arbiter state encodings and port identifiers.
package cpu_pkg;

    localparam int CPU_ADDR_W = 8;
    localparam int CPU_DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arbState_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LDR  = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker: round-robin against the last winner, or a fixed
// preference for the core port when fixed is set.
module rr_pick2
    import cpu_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic fixed,
    output logic valid,
    output logic id
);

    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            id = fixed ? PORT_CORE : ~last;
        end else begin
            id = req1 ? PORT_LDR : PORT_CORE;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port memory between the core (port 0) and the loader
// (port 1), one access at a time. Define ARB_LOCK_EN to add locked (atomic RMW) ownership.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = CPU_ADDR_W,
    parameter int DATA_W     = CPU_DATA_W,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              CLK,
    input  logic              CLB,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
`ifdef ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              gnt_id,
    output logic              busy
);

    arbState_e         stateQ, stateD;
    logic              rrLast, rrLastD;
    logic              accWe, accWeD;
    logic              pickReq0, pickReq1, pickValid, pickId;
    logic              ack0D, ack1D, memEnD, memWeD, gntIdD, busyD;
    logic [DATA_W-1:0] rdata0D, rdata1D, memWdataD;
    logic [ADDR_W-1:0] memAddrD;

`ifdef ARB_LOCK_EN
    logic lockActive, lockActiveD, lockId, lockIdD;

    // While a port holds the lock, the other port is invisible to the picker.
    assign pickReq0 = req0 && !(lockActive && lockId == PORT_LDR);
    assign pickReq1 = req1 && !(lockActive && lockId == PORT_CORE);
`else
    assign pickReq0 = req0;
    assign pickReq1 = req1;
`endif

    rr_pick2 u_pick (
        .req0  (pickReq0),
        .req1  (pickReq1),
        .last  (rrLast),
        .fixed (FIXED_PRIO),
        .valid (pickValid),
        .id    (pickId)
    );

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            ARB_IDLE:   if (pickValid) stateD = ARB_ACCESS;
            ARB_ACCESS: stateD = ARB_RESP;
            ARB_RESP:   stateD = ARB_IDLE;
            default:    stateD = ARB_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every target gets a default first (hold or idle value), so no path leaves one unassigned and no latch is inferred.
        ack0D     = 1'b0;
        ack1D     = 1'b0;
        memEnD    = 1'b0;
        memWeD    = 1'b0;
        rdata0D   = rdata0;
        rdata1D   = rdata1;
        memAddrD  = mem_addr;
        memWdataD = mem_wdata;
        gntIdD    = gnt_id;
        accWeD    = accWe;
        rrLastD   = rrLast;
        busyD     = (stateD != ARB_IDLE);
`ifdef ARB_LOCK_EN
        lockActiveD = lockActive;
        lockIdD     = lockId;
`endif
        case (stateQ)
            ARB_IDLE: begin
                if (pickValid) begin
                    gntIdD    = pickId;
                    rrLastD   = pickId;
                    memEnD    = 1'b1;
                    memWeD    = pickId ? we1 : we0;
                    accWeD    = pickId ? we1 : we0;
                    memAddrD  = pickId ? addr1 : addr0;
                    memWdataD = pickId ? wdata1 : wdata0;
`ifdef ARB_LOCK_EN
                    // An unlocked grant from the owner ends the lock once it is issued.
                    lockActiveD = pickId ? lock1 : lock0;
                    lockIdD     = pickId;
`endif
                end
            end
            ARB_RESP: begin
                if (gnt_id == PORT_LDR) begin
                    ack1D = 1'b1;
                    if (!accWe) rdata1D = mem_rdata;
                end else begin
                    ack0D = 1'b1;
                    if (!accWe) rdata0D = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLB) begin
            stateQ    <= ARB_IDLE;
            rrLast    <= 1'b1;
            accWe     <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            gnt_id    <= 1'b0;
            busy      <= 1'b0;
`ifdef ARB_LOCK_EN
            lockActive <= 1'b0;
            lockId     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            stateQ    <= stateD;
            rrLast    <= rrLastD;
            accWe     <= accWeD;
            ack0      <= ack0D;
            ack1      <= ack1D;
            rdata0    <= rdata0D;
            rdata1    <= rdata1D;
            mem_en    <= memEnD;
            mem_we    <= memWeD;
            mem_addr  <= memAddrD;
            mem_wdata <= memWdataD;
            gnt_id    <= gntIdD;
            busy      <= busyD;
`ifdef ARB_LOCK_EN
            lockActive <= lockActiveD;
            lockId     <= lockIdD;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin and a fixed-priority instance share
// all requester inputs, each with its own 1-cycle-latency memory model.
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          CLB;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
`ifdef ARB_LOCK_EN
    logic          lock0, lock1;
`endif

    logic          ack0, ack1, mem_en, mem_we, gnt_id, busy;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, memRdata;
    logic [AW-1:0] mem_addr;

    logic          ack0F, ack1F, memEnF, memWeF, gntIdF, busyF;
    logic [DW-1:0] rdata0F, rdata1F, memWdataF, memRdataF;
    logic [AW-1:0] memAddrF;

    logic [DW-1:0] memArr  [256];
    logic [DW-1:0] memArrF [256];
    logic          memLoad;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0)) dut (
        .CLK(CLK), .CLB(CLB),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(memRdata), .gnt_id(gnt_id), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1)) dutFix (
        .CLK(CLK), .CLB(CLB),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .ack0(ack0F), .ack1(ack1F), .rdata0(rdata0F), .rdata1(rdata1F),
        .mem_en(memEnF), .mem_we(memWeF), .mem_addr(memAddrF), .mem_wdata(memWdataF),
        .mem_rdata(memRdataF), .gnt_id(gntIdF), .busy(busyF)
    );

    always @(posedge CLK) begin
        if (memLoad) begin
            memArr[8'h10] <= 8'hA5;
            memArr[8'h20] <= 8'h5A;
        end else if (mem_en) begin
            if (mem_we) memArr[mem_addr] <= mem_wdata;
            memRdata <= memArr[mem_addr];
        end
    end

    always @(posedge CLK) begin
        if (memEnF) begin
            if (memWeF) memArrF[memAddrF] <= memWdataF;
            memRdataF <= memArrF[memAddrF];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic ack0Seen;

        CLB = 1'b1; memLoad = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
`ifdef ARB_LOCK_EN
        lock0 = 1'b0; lock1 = 1'b0;
`endif

        // Reset held two cycles with a pending core request
        req0 = 1'b1; addr0 = 8'h10;
        step();
        memLoad = 1'b0;
        step();
        check("rst acks", {ack0, ack1}, 2'b00);
        check("rst rdata", {rdata0, rdata1}, 16'h0000);
        check("rst mem bus", {mem_en, mem_we, mem_addr, mem_wdata}, 18'h0);
        check("rst gnt/busy", {gnt_id, busy}, 2'b00);
        check("rst fixed inst", {ack0F, ack1F, rdata0F, rdata1F, memEnF, memWeF,
                                 memAddrF, memWdataF, gntIdF, busyF}, 38'h0);
        req0 = 1'b0; CLB = 1'b0;
        step();
        check("idle no access", {mem_en, busy}, 2'b00);

        // Single read: mem_en one cycle after the sampling edge, ack two cycles later
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        step();
        check("rd access", {mem_en, mem_we, mem_addr, gnt_id, busy, ack0}, {1'b1, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0});
        step();
        check("rd resp", {mem_en, busy, ack0}, 3'b010);
        step();
        check("rd ack", {ack0, ack1, busy, rdata0}, {1'b1, 1'b0, 1'b0, 8'hA5});
        req0 = 1'b0;
        step();
        check("rd ack pulse", {ack0, mem_en, rdata0}, {1'b0, 1'b0, 8'hA5});

        // Contention: both ports held through four accesses
        CLB = 1'b1;
        step();
        CLB = 1'b0;
        req0 = 1'b1; req1 = 1'b1; addr0 = 8'h10; addr1 = 8'h20;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (mem_en !== 1'b1 && n < 8) begin step(); n++; end
            check($sformatf("rr grant %0d", k), {mem_en, gnt_id}, {1'b1, 1'(k % 2)});
            check($sformatf("fixed grant %0d", k), {memEnF, gntIdF}, 2'b10);
            if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
            step();
        end
        n = 0;
        while ((busy || busyF) && n < 8) begin step(); n++; end
        check("contention rdata", {rdata0, rdata1}, {8'hA5, 8'h5A});

        // Port 1 writes 0x3C to 0x7F; late input changes must not leak into the access
        step();
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h7F; wdata1 = 8'h3C;
        n = 0;
        while (mem_en !== 1'b1 && n < 8) begin step(); n++; end
        check("wr access", {mem_en, mem_we, gnt_id, mem_addr, mem_wdata}, {3'b111, 8'h7F, 8'h3C});
        addr1 = 8'h00; wdata1 = 8'hFF;
        n = 0;
        while (ack1 !== 1'b1 && n < 8) begin step(); n++; end
        check("wr ack1 keeps rdata1", {ack1, rdata1}, {1'b1, 8'h5A});
        req1 = 1'b0; we1 = 1'b0;
        step();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h7F;
        n = 0;
        while (ack0 !== 1'b1 && n < 8) begin step(); n++; end
        check("rd after wr", {ack0, rdata0}, {1'b1, 8'h3C});
        req0 = 1'b0;
        step();

        // Reset during RESP abandons the access without an ack
        req0 = 1'b1; addr0 = 8'h10;
        step();
        check("rst-mid access", mem_en, 1'b1);
        step();
        check("rst-mid in resp", {busy, mem_en, ack0}, 3'b100);
        CLB = 1'b1;
        step();
        CLB = 1'b0; req0 = 1'b0;
        check("rst-mid cleared", {ack0, busy, rdata0}, {2'b00, 8'h00});
        step();
        check("rst-mid no late ack", {ack0, mem_en}, 2'b00);
        req0 = 1'b1;
        n = 0;
        while (ack0 !== 1'b1 && n < 8) begin step(); n++; end
        check("post-rst read", {ack0, rdata0}, {1'b1, 8'hA5});
        req0 = 1'b0;
        step();

`ifdef ARB_LOCK_EN
        // Locked read-modify-write by port 1 while port 0 waits
        CLB = 1'b1;
        step();
        CLB = 1'b0;
        req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 8'h7F;
        step();
        check("lock first grant", {mem_en, gnt_id}, 2'b11);
        req0 = 1'b1; addr0 = 8'h10;
        ack0Seen = 1'b0;
        n = 0;
        while (ack1 !== 1'b1 && n < 8) begin step(); if (ack0) ack0Seen = 1'b1; n++; end
        check("lock rd ack", {ack1, rdata1}, {1'b1, 8'h3C});
        lock1 = 1'b0; we1 = 1'b1; addr1 = 8'h30; wdata1 = 8'h11;
        step();
        check("lock owner regrant", {mem_en, gnt_id, mem_we}, 3'b111);
        n = 0;
        while (ack1 !== 1'b1 && n < 8) begin step(); if (ack0) ack0Seen = 1'b1; n++; end
        check("lock wr ack", ack1, 1'b1);
        check("port0 held off", ack0Seen, 1'b0);
        req1 = 1'b0; we1 = 1'b0;
        n = 0;
        while (ack0 !== 1'b1 && n < 8) begin step(); n++; end
        check("port0 after unlock", {ack0, rdata0}, {1'b1, 8'hA5});
        req0 = 1'b0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
